// File: rtl/decode_execute_reg.sv
// decode_execute_reg: ID/EX pipeline register with load-use stall/bubble and flush; optional DEC_EX_PERF_EN adds bubble/flush counters
module decode_execute_reg #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteD,
  input  logic               ALUSrcD,
  input  logic               MemWriteD,
  input  logic               ResultSrcD,
  input  logic               BranchD,
  input  logic [2:0]         ALUControlD,
  input  logic [XLEN-1:0]    RD1D,
  input  logic [XLEN-1:0]    RD2D,
  input  logic [XLEN-1:0]    ImmExtD,
  input  logic [XLEN-1:0]    PCD,
  input  logic [XLEN-1:0]    PCPlus4D,
  input  logic [RADDR_W-1:0] Rs1D,
  input  logic [RADDR_W-1:0] Rs2D,
  input  logic [RADDR_W-1:0] RdD,
  input  logic               ValidD,
  input  logic               FlushE,
  output logic               StallF,
  output logic               StallD,
  output logic               RegWriteE,
  output logic               ALUSrcE,
  output logic               MemWriteE,
  output logic               ResultSrcE,
  output logic               BranchE,
  output logic [2:0]         ALUControlE,
  output logic [XLEN-1:0]    RD1E,
  output logic [XLEN-1:0]    RD2E,
  output logic [XLEN-1:0]    ImmExtE,
  output logic [XLEN-1:0]    PCE,
  output logic [XLEN-1:0]    PCPlus4E,
  output logic [RADDR_W-1:0] Rs1E,
  output logic [RADDR_W-1:0] Rs2E,
  output logic [RADDR_W-1:0] RdE,
  output logic               ValidE
`ifdef DEC_EX_PERF_EN
  ,
  output logic [31:0]        BubbleCnt,
  output logic [31:0]        FlushCnt
`endif
);
  logic hz, clr;
  // load in E whose destination is read by the instruction in D
  always_comb begin
    hz = ValidE & ResultSrcE & RegWriteE & (RdE != '0) & ValidD & ((RdE == Rs1D) | (RdE == Rs2D));
    StallF = hz & ~FlushE & ~rst;
    StallD = hz & ~FlushE & ~rst;
    clr = rst | FlushE | hz;
  end
  // E slot: cleared on reset/flush/bubble, otherwise captures D with control gated by ValidD
  always_ff @(posedge clk) begin
    if (clr) begin
      {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE} <= '0;
      {RD1E, RD2E, ImmExtE, PCE, PCPlus4E} <= '0;
      {Rs1E, Rs2E, RdE, ValidE} <= '0;
    end else begin
      RegWriteE   <= RegWriteD & ValidD;
      ALUSrcE     <= ALUSrcD & ValidD;
      MemWriteE   <= MemWriteD & ValidD;
      ResultSrcE  <= ResultSrcD & ValidD;
      BranchE     <= BranchD & ValidD;
      ALUControlE <= ValidD ? ALUControlD : 3'b000;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ImmExtE     <= ImmExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      ValidE      <= ValidD;
    end
  end
`ifdef DEC_EX_PERF_EN
  // count flushes and bubbles written into E
  always_ff @(posedge clk) begin
    if (rst) begin
      BubbleCnt <= '0;
      FlushCnt  <= '0;
    end else begin
      if (FlushE) FlushCnt <= FlushCnt + 32'd1;
      if (hz & ~FlushE) BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`endif
endmodule
